cnt_sched: RTL and testbench

CNT_SCHED -- requirements
Module: cnt_sched

---
 rtl/cnt_sched_pkg.sv | 15 +
 rtl/rr_arb2.sv | 20 ++
 rtl/cnt_sched.sv | 131 +++++++++++++
 tb/tb_cnt_sched.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
// Shared types and constants for the counter scheduler.
package cnt_sched_pkg;

    // Default counter width in bits.
    localparam int CNT_W_DEFAULT = 3;

    // Job lifecycle: wait for a request, load the start value, count, report completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : cnt_sched_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// A lone request always wins; on a tie the pointer names the winner.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] winner
);

    // One-hot winner selection; no request gives no winner.
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = ptr ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

endmodule : rr_arb2

// File: rtl/cnt_sched.sv
// Counter job scheduler: two requesters compete for a single up-counter.
// The winner's load value is counted up to all-ones, then a done pulse is
// returned to it. Every output comes straight from a register.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req,
    input  logic [2*W-1:0] ld_val,
    input  logic           hold,
    output logic [1:0]     gnt,
    output logic [1:0]     done,
    output logic [W-1:0]   q,
    output logic           busy,
    output logic           owner
);

    localparam logic [W-1:0] Q_MAX = '1;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_q;
    logic [W-1:0]   w_q_next;
    logic [W-1:0]   r_ld;
    logic [W-1:0]   w_ld_next;
    logic [1:0]     r_gnt;
    logic [1:0]     w_gnt_next;
    logic [1:0]     r_done;
    logic [1:0]     w_done_next;
    logic           r_busy;
    logic           w_busy_next;
    logic           r_owner;
    logic           w_owner_next;
    logic           r_ptr;
    logic           w_ptr_next;

    logic [1:0]     w_win;
    logic [W-1:0]   w_ld_sel;

    rr_arb2 u_arb (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_win)
    );

    // Load value belonging to whichever requester wins this cycle.
    assign w_ld_sel = w_win[1] ? ld_val[W +: W] : ld_val[0 +: W];

    // Next-state and next-output logic; registers hold unless a state says otherwise.
    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_ld_next    = r_ld;
        w_gnt_next   = 2'b00;
        w_done_next  = 2'b00;
        w_busy_next  = r_busy;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;

        case (r_state)
            ST_IDLE: begin
                // Requests are only looked at here; elsewhere they are ignored.
                if (req != 2'b00) begin
                    w_state_next = ST_LOAD;
                    w_owner_next = w_win[1];
                    w_ld_next    = w_ld_sel;
                    w_gnt_next   = w_win;
                    w_busy_next  = 1'b1;
                end
            end
            ST_LOAD: begin
                w_q_next     = r_ld;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                // Saturating count: reaching all-ones ends the job instead of wrapping.
                if (!hold) begin
                    if (r_q == Q_MAX) begin
                        w_state_next = ST_DONE;
                        w_done_next  = r_owner ? 2'b10 : 2'b01;
                    end else begin
                        w_q_next = r_q + W'(1);
                    end
                end
            end
            ST_DONE: begin
                // Hand priority to the requester that did not just finish.
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
                w_ptr_next   = ~r_owner;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_ld    <= '0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_busy  <= 1'b0;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_ld    <= w_ld_next;
            r_gnt   <= w_gnt_next;
            r_done  <= w_done_next;
            r_busy  <= w_busy_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign q     = r_q;
    assign busy  = r_busy;
    assign owner = r_owner;

endmodule : cnt_sched

// File: tb/tb_cnt_sched.sv
// Self-checking bench for cnt_sched (W=3): directed scenarios followed by
// random traffic, all compared every cycle against a job-age reference model.
module tb_cnt_sched;

    localparam int W    = 3;
    localparam int QMAX = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req;
    logic [2*W-1:0] ld_val;
    logic           hold;
    logic [1:0]     gnt;
    logic [1:0]     done;
    logic [W-1:0]   q;
    logic           busy;
    logic           owner;

    int checks = 0;
    int errors = 0;

    // Reference model: a job is described by its owner, start value and age
    // (cycles since the grant, not counting cycles frozen by hold).
    int m_active = 0;
    int m_age    = 0;
    int m_ld     = 0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_q      = 0;
    int e_gnt, e_done, e_busy;

    cnt_sched #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ld_val (ld_val),
        .hold   (hold),
        .gnt    (gnt),
        .done   (done),
        .q      (q),
        .busy   (busy),
        .owner  (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_step(input logic a_rst, input logic [1:0] a_req,
                              input logic [2*W-1:0] a_ld, input logic a_hold);
        int n;
        int w;
        if (!a_rst) begin
            m_active = 0; m_ptr = 0; m_q = 0; m_owner = 0;
        end else if (m_active == 0) begin
            if (a_req != 2'b00) begin
                if (a_req == 2'b11) w = m_ptr;
                else                w = (a_req == 2'b10) ? 1 : 0;
                m_active = 1;
                m_age    = 0;
                m_owner  = w;
                m_ld     = int'((a_ld >> (W * w)) & QMAX);
            end
        end else begin
            n = (1 << W) - m_ld;
            if (m_age == n + 1) begin
                m_active = 0;
                m_ptr    = 1 - m_owner;
            end else if (!(a_hold && m_age >= 1 && m_age <= n)) begin
                m_age++;
            end
        end
        n = (1 << W) - m_ld;
        e_gnt = 0; e_done = 0; e_busy = m_active;
        if (m_active != 0) begin
            if (m_age == 0)     e_gnt  = 1 << m_owner;
            if (m_age == n + 1) e_done = 1 << m_owner;
            if (m_age >= 1)     m_q    = (m_age <= n) ? (m_ld + m_age - 1) : QMAX;
        end
    endtask

    // One clock cycle: drive, let the edge happen, update the model, compare.
    task automatic cyc(input logic a_rst, input logic [1:0] a_req,
                       input logic [2*W-1:0] a_ld, input logic a_hold);
        rst = a_rst; req = a_req; ld_val = a_ld; hold = a_hold;
        @(posedge clk);
        model_step(a_rst, a_req, a_ld, a_hold);
        #1;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("q", 32'(q), 32'(m_q));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_busy != 0 || !a_rst) chk("owner", 32'(owner), 32'(m_owner));
        $display("t=%0t rst=%b req=%b ld=%o hold=%b | gnt=%b done=%b q=%0d busy=%b owner=%b",
                 $time, a_rst, a_req, a_ld, a_hold, gnt, done, q, busy, owner);
    endtask

    initial begin
        int idx;
        int holds_left;
        logic [31:0] r;

        // Reset state.
        cyc(1'b0, 2'b00, '0, 1'b0);
        cyc(1'b0, 2'b11, '1, 1'b0);
        chk("rst_q", 32'(q), 32'd0);

        // Requester 0, start value 5: q runs 5,6,7 then done.
        cyc(1'b1, 2'b01, 6'o05, 1'b0);
        chk("basic_gnt", 32'(gnt), 32'b01);
        cyc(1'b1, 2'b00, 6'o00, 1'b0);
        chk("basic_q5", 32'(q), 32'd5);
        cyc(1'b1, 2'b00, 6'o00, 1'b0);
        cyc(1'b1, 2'b00, 6'o00, 1'b0);
        chk("basic_q7", 32'(q), 32'd7);
        cyc(1'b1, 2'b00, 6'o00, 1'b0);
        chk("basic_done", 32'(done), 32'b01);
        cyc(1'b1, 2'b00, 6'o00, 1'b0);
        chk("basic_idle", 32'(busy), 32'd0);

        // Both requesting continuously: grants alternate 1,0,1,... (pointer now 1).
        for (int k = 0; k < 40; k++) cyc(1'b1, 2'b11, 6'o66, 1'b0);

        // Start value all-ones: LOAD, one RUN cycle, DONE in the third cycle.
        for (int k = 0; k < 20 && busy; k++) cyc(1'b1, 2'b00, 6'o00, 1'b0);
        cyc(1'b1, 2'b01, 6'o07, 1'b0);
        idx = 1;
        for (int k = 0; k < 20 && done == 2'b00; k++) begin
            cyc(1'b1, 2'b00, 6'o00, 1'b0);
            idx++;
        end
        chk("ld7_done_cycle", 32'(idx), 32'd3);

        // Hold for 4 edges at q=3 delays completion by 4 cycles; req drops after grant.
        cyc(1'b1, 2'b00, 6'o00, 1'b0);
        cyc(1'b1, 2'b01, 6'o00, 1'b0);
        idx = 1;
        holds_left = 4;
        for (int k = 0; k < 40 && done == 2'b00; k++) begin
            if (m_active != 0 && m_age == 4 && holds_left > 0) begin
                holds_left--;
                cyc(1'b1, 2'b00, 6'o00, 1'b1);
                chk("hold_q3", 32'(q), 32'd3);
            end else begin
                cyc(1'b1, 2'b00, 6'o00, 1'b0);
            end
            idx++;
        end
        chk("hold_done_cycle", 32'(idx), 32'd14);

        // Reset at q=6 mid-job aborts without done; pointer restarts at 0.
        cyc(1'b1, 2'b00, 6'o00, 1'b0);
        cyc(1'b1, 2'b01, 6'o02, 1'b0);
        for (int k = 0; k < 20 && q != 3'd6; k++) cyc(1'b1, 2'b00, 6'o00, 1'b0);
        chk("pre_rst_q6", 32'(q), 32'd6);
        cyc(1'b0, 2'b00, 6'o00, 1'b0);
        chk("abort_q0", 32'(q), 32'd0);
        chk("abort_nodone", 32'(done), 32'd0);
        cyc(1'b1, 2'b11, 6'o34, 1'b0);
        chk("post_rst_gnt0", 32'(gnt), 32'b01);

        // Requester 1 arrives mid-job: ignored until the job finishes.
        for (int k = 0; k < 20 && busy; k++) cyc(1'b1, 2'b10, 6'o00, 1'b0);
        cyc(1'b1, 2'b10, 6'o50, 1'b0);
        chk("late_req1_gnt", 32'(gnt), 32'b10);

        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            r = $urandom;
            cyc(r[15:10] != 6'd0, r[1:0], r[7:2], r[9:8] == 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cnt_sched
